// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard : tracks in-flight register writes (EX/MEM/WB) and raises
//                     the ID-stage interlock plus a saturating stall counter.
// Revision 1.0 : initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int DATA_FORWARDING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [1:0]  id_rs,
  input  logic [1:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_reg_write,
  input  logic [1:0]  id_write_reg,
  input  logic        id_mem_read,
  input  logic        flush,
  output logic        stall,
  output logic [3:0]  pending_mask,
  output logic [15:0] stall_count
);

  localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

  logic       r_ex_valid, r_mem_valid, r_wb_valid;
  logic [1:0] r_ex_dest, r_mem_dest, r_wb_dest;
  logic       r_ex_load, r_mem_load, r_wb_load;
  logic [15:0] r_stall_count;

  logic [3:0] w_need;
  logic [3:0] w_ex_hot, w_mem_hot, w_wb_hot;
  logic       w_hazard;
  logic       w_stall;
  logic       w_issue;

  // One-hot views of the ID source reads and of each occupied slot.
  always_comb begin
    w_need = 4'b0000;
    if (id_valid) begin
      if (id_use_rs) w_need = w_need | (4'b0001 << id_rs);
      if (id_use_rt) w_need = w_need | (4'b0001 << id_rt);
    end
    w_ex_hot  = r_ex_valid  ? (4'b0001 << r_ex_dest)  : 4'b0000;
    w_mem_hot = r_mem_valid ? (4'b0001 << r_mem_dest) : 4'b0000;
    w_wb_hot  = r_wb_valid  ? (4'b0001 << r_wb_dest)  : 4'b0000;
  end

  generate
    if (DATA_FORWARDING != 0) begin : g_fwd
      // Only a load still in EX cannot be forwarded in time.
      assign w_hazard = r_ex_load & (|(w_ex_hot & w_need));
    end else begin : g_nofwd
      // WB is included: the register file write lands at the end of WB.
      assign w_hazard = |((w_ex_hot | w_mem_hot | w_wb_hot) & w_need);
    end
  endgenerate

  assign w_stall = w_hazard & ~flush;
  assign w_issue = id_valid & ~w_stall & ~flush & id_reg_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_dest   <= 2'd0;
      r_ex_load   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_dest  <= 2'd0;
      r_mem_load  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_dest   <= 2'd0;
      r_wb_load   <= 1'b0;
    end else begin
      r_wb_valid  <= r_mem_valid;
      r_wb_dest   <= r_mem_dest;
      r_wb_load   <= r_mem_load;
      r_mem_valid <= r_ex_valid;
      r_mem_dest  <= r_ex_dest;
      r_mem_load  <= r_ex_load;
      r_ex_valid  <= w_issue;
      r_ex_dest   <= id_write_reg;
      r_ex_load   <= id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 16'd0;
    end else if (w_stall && (r_stall_count != c_COUNT_MAX)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  // The load flag retires with WB; kept for symmetry of the slot record.
  logic w_unused;
  assign w_unused = r_wb_load;

  assign stall        = w_stall;
  assign pending_mask = w_ex_hot | w_mem_hot | w_wb_hot;
  assign stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side companion to the EX-stage operand-forwarding logic: tracks every register write in flight from issue (ID→EX) to retirement (end of WB) and raises an interlock when the instruction in ID reads a register whose value forwarding cannot yet supply. It sits beside the ID stage. Its `stall` output freezes PC and IF/ID and injects a bubble into ID/EX. It also exports the in-flight write set and a stall-cycle performance counter.

## Interface
- `DATA_FORWARDING`, default 1: 1 means the forwarding network is present, so only load-use hazards stall. 0 means any in-flight write to a source register stalls.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `id_valid`, input, 1: ID holds a real instruction.
- `id_rs`, input, 2: first source register.
- `id_rt`, input, 2: second source register.
- `id_use_rs`, input, 1: instruction reads `id_rs`.
- `id_use_rt`, input, 1: instruction reads `id_rt`.
- `id_reg_write`, input, 1: instruction writes a register.
- `id_write_reg`, input, 2: destination register.
- `id_mem_read`, input, 1: instruction is a load; its result is available only from MEM output onward.
- `flush`, input, 1: squash the ID instruction (taken branch/jump); it is not issued.
- `stall`, output, 1: combinational interlock; hold PC and IF/ID, bubble into EX.
- `pending_mask`, output, 4: combinational; bit r is set while any valid slot's destination equals r.
- `stall_count`, output, 16: registered count of stall cycles, saturating.

## Operation
- The block holds three tag slots, EX, MEM and WB, mirroring the pipeline. Each slot has the fields {valid, dest[1:0], load}.
- A source "needs" register r when (`id_use_rs` & `id_rs`==r) | (`id_use_rt` & `id_rt`==r), qualified by `id_valid`.
- The stall rule depends on `DATA_FORWARDING`:
  - When 1: `stall` = EX.valid & EX.load & EX.dest is needed. At most 1 stall cycle per load-use pair.
  - When 0: `stall` = any of EX/MEM/WB is valid with dest needed. The WB slot counts because the RF write lands at the end of that cycle.
- `flush` has priority over the stall check: `stall` = 0 whenever `flush`=1. A squashed instruction never stalls.
- Issue condition is `id_valid & ~stall & ~flush & id_reg_write`. Non-writing instructions, bubbles and squashed instructions enter EX as valid=0.
- The slot shift occurs every cycle, unconditionally:
  - WB ← MEM.
  - MEM ← EX.
  - EX ← {issue, `id_write_reg`, `id_mem_read`}.
- WB retires on the following edge by being overwritten.
- Two slots may hold the same dest (back-to-back writes). `pending_mask` ORs them, and the stall check matches any of them.
- `stall_count` increments by 1 on each edge where `stall`=1. It holds at 16'hFFFF once saturated.

## Timing
- Reset: all slot valid bits = 0, `stall_count` = 0. Consequently `stall`=0 and `pending_mask`=4'b0000 in the cycle after reset.
- Reset asserted mid-operation discards all in-flight tags on that edge. A reset edge never increments `stall_count`.
- `stall` and `pending_mask` are combinational from the ID inputs and the slot registers. There are no registered outputs other than `stall_count`.
- Tag lifetime: an instruction issued at edge t occupies EX during cycle t+1, MEM during t+2 and WB during t+3, and is gone from t+4.
- Load-use with forwarding: a dependent instruction held in ID stalls exactly 1 cycle. The next cycle its producer is in MEM, and the forwarding network supplies it.
- Without forwarding, a dependent instruction directly behind its producer stalls 3 cycles. With one independent instruction between them it stalls 2 cycles; with three or more between them it does not stall.

## Test plan
- Reset, then load R1 followed immediately by `ADD R2,R1,R0` (DATA_FORWARDING=1): `stall`=1 for exactly 1 cycle, `stall_count`=1, and the ADD issues on the next edge.
- ALU write R3 followed by a reader of R3 (DATA_FORWARDING=1): `stall` is never asserted, and `pending_mask`=4'b1000 for 3 cycles after issue.
- DATA_FORWARDING=0, write R1 then a dependent instruction: `stall` held for 3 consecutive cycles, `stall_count`=3. Repeat with 1 independent instruction between them: `stall` for 2 cycles.
- Load R2 in EX, ID reads R2 with `flush`=1 in the same cycle: `stall`=0, EX receives a bubble, `stall_count` unchanged.
- Two back-to-back writes to R0, then `reset` pulsed while both are in flight: `pending_mask`=4'b0001 before reset, 4'b0000 the cycle after, and `stall_count`=0.
- Force 65,540 stall cycles (DATA_FORWARDING=0, continuous dependents): `stall_count` saturates at 16'hFFFF.
